// File: rtl/prog_cascade_counter.sv
// rtl/prog_cascade_counter.sv - programmable up/down cascaded nibble counter with compare and one-shot
//
// Purpose: W-bit counter built from NIB cascaded 4-bit stages. Counts up or
// down, either free-running with wrap or one-shot (stops and flags DONE at
// the terminal value). Emits a one-cycle MATCH pulse after any count step
// whose resulting value equals CMP.
//
// Ports:
//   CK      in   1    clock, rising edge
//   RN      in   1    asynchronous active-low reset
//   EN      in   1    count enable
//   DIR     in   1    0 = up, 1 = down
//   MODE    in   1    0 = free-run with wrap, 1 = one-shot
//   CLR     in   1    synchronous clear (highest priority)
//   LD      in   1    synchronous load of LD_VAL
//   LD_VAL  in   W    load value
//   CMP     in   W    compare value
//   Q       out  W    registered count
//   CY      out  NIB  per-stage carry/borrow-in (combinational)
//   TC      out  1    terminal count (combinational)
//   MATCH   out  1    registered one-cycle compare pulse
//   DONE    out  1    registered sticky one-shot completion flag
//
// W is derived from NIB and must be left at its default.

module prog_cascade_counter #(
  parameter int NIB = 4,
  parameter int W   = 4 * NIB
) (
  input  logic           CK,
  input  logic           RN,
  input  logic           EN,
  input  logic           DIR,
  input  logic           MODE,
  input  logic           CLR,
  input  logic           LD,
  input  logic [W-1:0]   LD_VAL,
  input  logic [W-1:0]   CMP,
  output logic [W-1:0]   Q,
  output logic [NIB-1:0] CY,
  output logic           TC,
  output logic           MATCH,
  output logic           DONE
);

  logic [W-1:0]   q_q, q_d;
  logic           match_q, match_d;
  logic           done_q, done_d;
  logic [W-1:0]   q_step;
  logic [NIB-1:0] cy_w;
  logic           tc_w;
  logic           step_w;

  // Ripple the carry/borrow through the stages. A running local carry keeps
  // the chain free of self-referencing vector reads.
  always_comb begin
    logic       c;
    logic [3:0] nib;
    logic [3:0] term;
    term   = DIR ? 4'h0 : 4'hF;
    c      = EN & ~done_q;
    cy_w   = '0;
    q_step = q_q;
    tc_w   = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      nib     = q_q[4*k +: 4];
      cy_w[k] = c;
      if (c) begin
        q_step[4*k +: 4] = DIR ? (nib - 4'd1) : (nib + 4'd1);
      end
      c = c & (nib == term);
    end
    // Carry out of the top stage means every nibble sits at its terminal value.
    tc_w = c;
  end

  // A count step is only possible when neither clear nor load wins this cycle.
  assign step_w = EN & ~CLR & ~LD & ~done_q;

  always_comb begin
    q_d     = q_q;
    done_d  = done_q;
    match_d = 1'b0;
    if (CLR) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (LD) begin
      q_d    = LD_VAL;
      done_d = 1'b0;
    end else if (step_w) begin
      if (MODE && tc_w) begin
        // One-shot: park on the terminal value instead of wrapping.
        q_d    = q_q;
        done_d = 1'b1;
      end else begin
        q_d = q_step;
      end
      match_d = (q_d == CMP);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      q_q     <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign CY    = cy_w;
  assign TC    = tc_w;
  assign MATCH = match_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_prog_cascade_counter.sv
// tb/tb_prog_cascade_counter.sv - directed self-checking bench for prog_cascade_counter

module tb_prog_cascade_counter;

  logic        CK = 1'b0;
  logic        RN;
  logic        EN, DIR, MODE, CLR, LD;
  logic [15:0] LD_VAL, CMP;
  logic [15:0] Q;
  logic [3:0]  CY;
  logic        TC, MATCH, DONE;

  int errors = 0;
  int checks = 0;

  prog_cascade_counter #(.NIB(4)) dut (
    .CK(CK), .RN(RN), .EN(EN), .DIR(DIR), .MODE(MODE), .CLR(CLR), .LD(LD),
    .LD_VAL(LD_VAL), .CMP(CMP), .Q(Q), .CY(CY), .TC(TC), .MATCH(MATCH), .DONE(DONE)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  initial begin
    RN = 1'b0; EN = 1'b0; DIR = 1'b0; MODE = 1'b0; CLR = 1'b0; LD = 1'b0;
    LD_VAL = 16'h0000; CMP = 16'hABCD;
    #1;
    chk("rst_q", Q, 16'h0000);
    chk("rst_match", MATCH, 0);
    chk("rst_done", DONE, 0);
    @(negedge CK);
    RN = 1'b1;

    // Free-run up wrap
    EN = 1; LD = 1; LD_VAL = 16'hFFFE; tick(); LD = 0;
    chk("wrap_ld_q", Q, 16'hFFFE);
    chk("wrap_ld_cy", CY, 4'b0001);
    chk("wrap_ld_tc", TC, 0);
    tick();
    chk("wrap_ffff_q", Q, 16'hFFFF);
    chk("wrap_ffff_cy", CY, 4'b1111);
    chk("wrap_ffff_tc", TC, 1);
    tick();
    chk("wrap_0000_q", Q, 16'h0000);
    chk("wrap_done", DONE, 0);
    chk("wrap_0000_cy", CY, 4'b0001);

    // Cascade carry and borrow across nibbles
    LD = 1; LD_VAL = 16'h00FF; tick(); LD = 0;
    chk("cas_up_cy", CY, 4'b0111);
    chk("cas_up_tc", TC, 0);
    tick();
    chk("cas_up_q", Q, 16'h0100);
    DIR = 1; #1;
    chk("cas_dn_cy", CY, 4'b0111);
    tick();
    chk("cas_dn_q", Q, 16'h00FF);
    DIR = 0;

    // Compare pulse; load to CMP does not pulse
    CMP = 16'h0010; LD = 1; LD_VAL = 16'h000E; tick(); LD = 0;
    chk("cmp_ld_q", Q, 16'h000E);
    chk("cmp_ld_match", MATCH, 0);
    tick();
    chk("cmp_0f_match", MATCH, 0);
    tick();
    chk("cmp_10_q", Q, 16'h0010);
    chk("cmp_10_match", MATCH, 1);
    tick();
    chk("cmp_11_q", Q, 16'h0011);
    chk("cmp_11_match", MATCH, 0);
    LD = 1; LD_VAL = 16'h0010; tick(); LD = 0; EN = 0;
    chk("cmp_ldeq_q", Q, 16'h0010);
    chk("cmp_ldeq_match", MATCH, 0);
    tick();
    chk("cmp_hold_q", Q, 16'h0010);
    chk("cmp_hold_match", MATCH, 0);
    chk("cmp_hold_cy", CY, 4'b0000);
    CMP = 16'hABCD;

    // Priority CLR > LD > count
    EN = 1; CLR = 1; LD = 1; LD_VAL = 16'h1234; tick(); CLR = 0;
    chk("pri_clr_q", Q, 16'h0000);
    tick(); LD = 0;
    chk("pri_ld_q", Q, 16'h1234);
    tick();
    chk("pri_cnt_q", Q, 16'h1235);

    // One-shot down count to zero, CMP at terminal value
    MODE = 1; DIR = 1; CMP = 16'h0000; LD = 1; LD_VAL = 16'h0002; tick(); LD = 0;
    chk("os_ld_q", Q, 16'h0002);
    chk("os_ld_done", DONE, 0);
    tick();
    chk("os_1_q", Q, 16'h0001);
    chk("os_1_tc", TC, 0);
    tick();
    chk("os_0_q", Q, 16'h0000);
    chk("os_0_done", DONE, 0);
    chk("os_0_tc", TC, 1);
    chk("os_0_match", MATCH, 1);
    tick();
    chk("os_hold_q", Q, 16'h0000);
    chk("os_hold_done", DONE, 1);
    chk("os_hold_tc", TC, 0);
    chk("os_hold_cy", CY, 4'b0000);
    chk("os_hold_match", MATCH, 1);
    tick();
    chk("os_hold2_q", Q, 16'h0000);
    chk("os_hold2_match", MATCH, 0);
    EN = 0; tick(); EN = 1; tick();
    chk("os_en_q", Q, 16'h0000);
    chk("os_en_done", DONE, 1);
    LD = 1; LD_VAL = 16'h0005; tick(); LD = 0;
    chk("os_reld_q", Q, 16'h0005);
    chk("os_reld_done", DONE, 0);
    chk("os_reld_match", MATCH, 0);

    // Asynchronous reset mid-count with a pending MATCH
    MODE = 0; DIR = 0; CMP = 16'h1234; LD = 1; LD_VAL = 16'h1233; tick(); LD = 0;
    tick();
    chk("ar_pre_q", Q, 16'h1234);
    chk("ar_pre_match", MATCH, 1);
    #2 RN = 0;
    #1;
    chk("ar_q", Q, 16'h0000);
    chk("ar_match", MATCH, 0);
    chk("ar_done", DONE, 0);
    #2 RN = 1; CMP = 16'hABCD;
    tick();
    chk("ar_first_q", Q, 16'h0001);
    chk("ar_first_match", MATCH, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_cascade_counter.md
PROG_CASCADE_COUNTER -- requirements
Module: prog_cascade_counter

Interface
REQ-001 Parameter NIB, default 4, number of cascaded 4-bit counter stages (legal 1..8).
REQ-002 Parameter W, default 4*NIB, counter width; derived, SHALL NOT be overridden independently.
REQ-003 CK  input  1  single clock, all state updates on rising edge.
REQ-004 RN  input  1  asynchronous active-low reset.
REQ-005 EN  input  1  count enable; one step per cycle when high.
REQ-006 DIR  input  1  count direction: 0 up, 1 down.
REQ-007 MODE  input  1  0 free-run with wrap, 1 one-shot (stop at terminal).
REQ-008 CLR  input  1  synchronous clear to zero.
REQ-009 LD  input  1  synchronous load of LD_VAL.
REQ-010 LD_VAL  input  W  load value.
REQ-011 CMP  input  W  compare value.
REQ-012 Q  output  W  registered counter value.
REQ-013 CY  output  NIB  per-stage carry/borrow-in, combinational.
REQ-014 TC  output  1  terminal count, combinational.
REQ-015 MATCH  output  1  registered one-cycle compare pulse.
REQ-016 DONE  output  1  registered sticky one-shot completion flag.

Function
REQ-017 Per-cycle priority SHALL be CLR > LD > count > hold.
REQ-018 CLR: Q<=0, DONE<=0, MATCH<=0, regardless of EN/LD.
REQ-019 LD (CLR low): Q<=LD_VAL, DONE<=0, MATCH<=0.
REQ-020 Count step occurs when EN=1, CLR=0, LD=0 and DONE=0; otherwise Q holds.
REQ-021 Step: up Q<=Q+1 mod 2^W; down Q<=Q-1 mod 2^W; no saturation in MODE=0.
REQ-022 Terminal value: all-ones for DIR=0, zero for DIR=1.
REQ-023 TC = EN & ~DONE & (Q == terminal value for current DIR).
REQ-024 CY[0] = EN & ~DONE; CY[k] = CY[k-1] & (nibble k-1 at its terminal value for DIR); stage k advances iff CY[k] during a count step.
REQ-025 MODE=1 and TC during a count step: Q holds at terminal value, DONE<=1 next edge, no wrap.
REQ-026 While DONE=1, EN ignored, TC=0, CY all 0; cleared only by CLR, LD or reset.
REQ-027 MODE=0 and TC: Q wraps, DONE unaffected (stays 0).
REQ-028 MATCH<=1 for exactly the cycle following a count step whose resulting Q equals CMP; 0 otherwise.
REQ-029 Load or clear to a value equal to CMP SHALL NOT assert MATCH.
REQ-030 One-shot terminal hold: MATCH<=1 if terminal value equals CMP; no repeat pulses while DONE held.
REQ-031 DIR or MODE change takes effect on the next count step; no state disturbance.
REQ-032 CMP change mid-count: compared combinationally against next Q at each step.

Reset
REQ-033 RN low asynchronously forces Q=0, MATCH=0, DONE=0 without waiting for CK.
REQ-034 RN deassertion synchronous to CK by system; first count step on first rising edge with RN high and EN high.
REQ-035 Reset mid-count or mid-one-shot discards all state; no pending MATCH after release.

Verification (NIB=4, W=16)
REQ-036 RN low during count at Q=0x1234 -> Q=0, MATCH=0, DONE=0 before next CK edge.
REQ-037 MODE=0 DIR=0 LD 0xFFFE, EN=1 -> Q 0xFFFF (TC=1, CY=4'b1111) then 0x0000, DONE stays 0.
REQ-038 MODE=1 DIR=1 LD 0x0002, EN=1 -> Q 1, 0, holds 0; DONE=1 after the TC step; EN ignored until LD.
REQ-039 CMP=0x0010, LD 0x000E, EN=1 -> MATCH one-cycle pulse with Q=0x0010; LD 0x0010 -> no MATCH.
REQ-040 CLR and LD same cycle with EN=1 -> Q=0; LD alone with EN=1 -> Q=LD_VAL, no increment that cycle.
REQ-041 DIR=0 Q=0x00FF EN=1 -> CY=4'b0111, next Q=0x0100; DIR=1 Q=0x0100 -> CY=4'b0111, next Q=0x00FF.
